result_packer: RTL and testbench

- Sits directly downstream of the 32-bit adder and upstream of the memory write path.
- Captures sums, tagged lower or upper by the controller's buffer_control signal, and packs two DATA_W halves into one MEM_WORD_SIZE word.
- Queues packed words in a small FIFO and presents them to the write side with a valid/ready handshake.
- Flags per-half carry-out and handshake ordering errors.

---
 rtl/result_packer.sv | 244 ++++++++++++++++++++++++
 tb/tb_result_packer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// Module   : result_packer
// Purpose  : Packs pairs of adder result halves (lower/upper, tagged by the
//            controller's buffer_control encoding) into one memory word,
//            queues packed words in a small FIFO and presents them to the
//            memory write path through a valid/ready handshake. Per-half
//            carry flags travel with each word. A sticky flag records any
//            out-of-order half.
//
// Ports    : clk_i        clock, all state changes on the rising edge
//            rst_i        synchronous active-high reset
//            in_valid_i   adder result presented
//            in_ready_o   block can take a result this cycle
//            in_data_i    adder sum (DATA_W)
//            in_carry_i   adder carry-out for this sum
//            in_upper_i   1 = upper half, 0 = lower half
//            flush_i      commit a pending lower half, upper zero-filled
//            out_valid_o  FIFO head entry valid
//            out_ready_i  write side consumes the head entry
//            out_data_o   packed word {upper, lower} (MEM_WORD_SIZE)
//            out_ovf_o    carry flags of head entry {upper, lower}
//            count_o      FIFO occupancy
//            err_order_o  sticky ordering error, cleared only by reset
//
// Options  : RESULT_PACKER_SAT_EN - when defined, a half whose carry is set
//            is replaced by all-ones before packing; out_ovf_o still reports
//            the carry. When undefined, halves pass through and wrap.
//
// Params   : DATA_W (32), MEM_WORD_SIZE (64, must be 2*DATA_W),
//            DEPTH (2, power of two, >= 2)
//
// Revision : 1.0 - initial release
// ============================================================================
module result_packer #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int DEPTH         = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic                       in_carry_i,
    input  logic                       in_upper_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [MEM_WORD_SIZE-1:0]   out_data_o,
    output logic [1:0]                 out_ovf_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_order_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // Assembly state: either nothing is pending, or a lower half is held
    // waiting for its upper partner.
    localparam logic [0:0] c_S_EMPTY      = 1'b0;
    localparam logic [0:0] c_S_HAVE_LOWER = 1'b1;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [0:0]               r_state;
    logic [DATA_W-1:0]        r_low;
    logic                     r_low_carry;
    logic                     r_err;

    logic [MEM_WORD_SIZE-1:0] r_mem_data [DEPTH];
    logic [1:0]               r_mem_ovf  [DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_CNT_W-1:0]       r_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                     w_full;
    logic                     w_in_acc;
    logic                     w_pop;
    logic [DATA_W-1:0]        w_in_half;

    logic [0:0]               w_state_nxt;
    logic                     w_push;
    logic [MEM_WORD_SIZE-1:0] w_push_data;
    logic [1:0]               w_push_ovf;
    logic                     w_store_low;
    logic                     w_set_err;

    // Fullness comes only from the registered count: a pop in the same cycle
    // does not reopen the input, which keeps in_ready_o off the out_ready_i
    // timing path.
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign in_ready_o = !w_full && !flush_i;
    assign w_in_acc   = in_valid_i && in_ready_o;

    assign out_valid_o = (r_count != '0);
    assign w_pop       = out_valid_o && out_ready_i;

    // Half value as it will be stored/packed. The carry itself is always
    // forwarded untouched on the ovf bits.
`ifdef RESULT_PACKER_SAT_EN
    assign w_in_half = in_carry_i ? {DATA_W{1'b1}} : in_data_i;
`else
    assign w_in_half = in_data_i;
`endif

    // ------------------------------------------------------------------------
    // Assembly state machine: decides what (if anything) is pushed this cycle
    // and whether the incoming half is kept as the new pending lower.
    // At most one word is pushed per cycle, and a push only happens when the
    // FIFO is not full (either via in_ready_o or the explicit flush guard).
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = '0;
        w_push_ovf  = 2'b00;
        w_store_low = 1'b0;
        w_set_err   = 1'b0;

        case (r_state)
            c_S_EMPTY: begin
                if (w_in_acc) begin
                    if (in_upper_i) begin
                        // Upper without a lower: emit it alone, lower zeroed.
                        w_push      = 1'b1;
                        w_push_data = {w_in_half, {DATA_W{1'b0}}};
                        w_push_ovf  = {in_carry_i, 1'b0};
                        w_set_err   = 1'b1;
                    end else begin
                        w_store_low = 1'b1;
                        w_state_nxt = c_S_HAVE_LOWER;
                    end
                end
                // flush_i with nothing pending is a no-op.
            end

            c_S_HAVE_LOWER: begin
                if (w_in_acc) begin
                    if (in_upper_i) begin
                        w_push      = 1'b1;
                        w_push_data = {w_in_half, r_low};
                        w_push_ovf  = {in_carry_i, r_low_carry};
                        w_state_nxt = c_S_EMPTY;
                    end else begin
                        // Second lower in a row: retire the old one with a
                        // zero upper and keep the new one pending.
                        w_push      = 1'b1;
                        w_push_data = {{DATA_W{1'b0}}, r_low};
                        w_push_ovf  = {1'b0, r_low_carry};
                        w_store_low = 1'b1;
                        w_set_err   = 1'b1;
                    end
                end else if (flush_i && !w_full) begin
                    // Flush never coincides with acceptance since it forces
                    // in_ready_o low. When full the flush simply waits.
                    w_push      = 1'b1;
                    w_push_data = {{DATA_W{1'b0}}, r_low};
                    w_push_ovf  = {1'b0, r_low_carry};
                    w_state_nxt = c_S_EMPTY;
                end
            end

            default: begin
                w_state_nxt = c_S_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Assembly register, state and sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_S_EMPTY;
            r_low       <= '0;
            r_low_carry <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_store_low) begin
                r_low       <= w_in_half;
                r_low_carry <= in_carry_i;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage. Entries are cleared on reset so the head reads as zero
    // straight out of reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_ovf[i]  <= 2'b00;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_ovf[r_wr_ptr]  <= w_push_ovf;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy. DEPTH is a power of two, so the natural
    // pointer wrap gives modulo-DEPTH addressing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: head entry straight from the storage registers, so it stays
    // stable until the read pointer moves.
    // ------------------------------------------------------------------------
    assign out_data_o  = r_mem_data[r_rd_ptr];
    assign out_ovf_o   = r_mem_ovf[r_rd_ptr];
    assign count_o     = r_count;
    assign err_order_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_packer
// Purpose  : Self-checking bench for result_packer. A queue-based reference
//            model predicts the FIFO contents, occupancy and error flag; each
//            scenario task checks the DUT against it or against fixed words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_packer;

    localparam int DATA_W = 32;
    localparam int MW     = 64;
    localparam int DEPTH  = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [31:0]   in_data_i = '0;
    logic          in_carry_i = 1'b0;
    logic          in_upper_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [63:0]   out_data_o;
    logic [1:0]    out_ovf_o;
    logic [CW-1:0] count_o;
    logic          err_order_o;

    always #5 clk = ~clk;

    result_packer #(
        .DATA_W        (DATA_W),
        .MEM_WORD_SIZE (MW),
        .DEPTH         (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_carry_i  (in_carry_i),
        .in_upper_i  (in_upper_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ovf_o   (out_ovf_o),
        .count_o     (count_o),
        .err_order_o (err_order_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {ovf[1:0], word[63:0]} plus the pending half.
    logic [65:0] m_q[$];
    bit          m_have;
    logic [31:0] m_low;
    logic        m_lcar;
    logic        m_err;

    function automatic logic [31:0] sat_half(input logic [31:0] d, input logic c);
`ifdef RESULT_PACKER_SAT_EN
        return c ? 32'hFFFF_FFFF : d;
`else
        return d;
`endif
    endfunction

    // Applies one cycle of stimulus and advances the model across the edge.
    // Returns at posedge+1 with the inputs still applied.
    task automatic drive(input logic v, input logic [31:0] d, input logic c,
                         input logic u, input logic f, input logic r,
                         output logic acc);
        bit          notfull;
        bit          pop;
        logic [31:0] h;
        @(negedge clk);
        in_valid_i  = v;
        in_data_i   = d;
        in_carry_i  = c;
        in_upper_i  = u;
        flush_i     = f;
        out_ready_i = r;
        notfull = (m_q.size() < DEPTH);
        acc     = v && notfull && !f;
        pop     = (m_q.size() != 0) && r;
        h       = sat_half(d, c);
        if (pop) m_q.delete(0);
        if (acc) begin
            if (u) begin
                if (m_have) m_q.push_back({c, m_lcar, h, m_low});
                else begin
                    m_q.push_back({c, 1'b0, h, 32'h0});
                    m_err = 1'b1;
                end
                m_have = 0;
            end else begin
                if (m_have) begin
                    m_q.push_back({1'b0, m_lcar, 32'h0, m_low});
                    m_err = 1'b1;
                end
                m_have = 1;
                m_low  = h;
                m_lcar = c;
            end
        end else if (f && m_have && notfull) begin
            m_q.push_back({1'b0, m_lcar, 32'h0, m_low});
            m_have = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        @(negedge clk);
        rst_i       = 1'b1;
        in_valid_i  = v;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        m_q.delete();
        m_have = 0;
        m_low  = '0;
        m_lcar = 1'b0;
        m_err  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        in_upper_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++;
        if ({out_valid_o, count_o, err_order_o} !== {1'b0, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b count=%0d err=%b, exp 0/0/0",
                     out_valid_o, count_o, err_order_o);
        end
        checks++;
        if ({out_ovf_o, out_data_o} !== 66'h0) begin
            errors++;
            $display("FAIL reset_data: got %b_%h, exp 00_0", out_ovf_o, out_data_o);
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 1", in_ready_o);
        end
    endtask

    task automatic test_pair();
        logic acc;
        do_reset(1'b0);
        drive(1, 32'h5, 0, 0, 0, 1, acc);
        drive(1, 32'hA, 0, 1, 0, 1, acc);
        checks++;
        if ({out_valid_o, out_ovf_o, out_data_o} !== {1'b1, 2'b00, 64'h0000000A_00000005}) begin
            errors++;
            $display("FAIL pair_word: got v=%b %b_%h exp v=1 00_0000000a00000005",
                     out_valid_o, out_ovf_o, out_data_o);
        end
        drive(0, 32'h0, 0, 0, 0, 1, acc);
        checks++;
        if ({out_valid_o, count_o} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL pair_drain: got v=%b count=%0d exp 0/0", out_valid_o, count_o);
        end
    endtask

    task automatic test_backpressure();
        logic        acc;
        logic [63:0] exp_w [3];
        int          idx;
        int          h3;
        do_reset(1'b0);
        for (int p = 0; p < 3; p++) exp_w[p] = {32'h20 + p, 32'h10 + p};
        for (int p = 0; p < 2; p++) begin
            drive(1, 32'h10 + p, 0, 0, 0, 0, acc);
            drive(1, 32'h20 + p, 0, 1, 0, 0, acc);
        end
        // Third pair stalls while the write side holds off.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h12, 0, 0, 0, 0, acc);
            checks++;
            if ({count_o, in_ready_o, out_data_o} !== {CW'(2), 1'b0, exp_w[0]}) begin
                errors++;
                $display("FAIL bp_stall: got count=%0d rdy=%b head=%h exp 2/0/%h",
                         count_o, in_ready_o, out_data_o, exp_w[0]);
            end
        end
        idx = 0;
        h3  = 0;
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            if (out_valid_o) begin
                checks++;
                if (out_data_o !== exp_w[idx]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h exp %h", idx, out_data_o, exp_w[idx]);
                end
                idx++;
            end
            drive(h3 < 2, (h3 == 1) ? 32'h22 : 32'h12, 0, h3 == 1, 0, 1, acc);
            if (acc) h3++;
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL bp_timeout: got %0d words exp 3", idx);
        end
    endtask

    task automatic test_overflow();
        logic        acc;
        logic [65:0] exp2;
        do_reset(1'b0);
        drive(1, 32'hFFFF_FFFF, 1, 0, 0, 0, acc);
        drive(1, 32'h1, 0, 1, 0, 0, acc);
        checks++;
        if ({out_ovf_o, out_data_o} !== {2'b01, 64'h00000001_FFFFFFFF}) begin
            errors++;
            $display("FAIL ovf_wrap: got %b_%h exp 01_00000001ffffffff", out_ovf_o, out_data_o);
        end
        drive(0, 32'h0, 0, 0, 0, 1, acc);
        drive(1, 32'h10, 1, 0, 0, 0, acc);
        drive(1, 32'h2, 0, 1, 0, 0, acc);
`ifdef RESULT_PACKER_SAT_EN
        exp2 = {2'b01, 64'h00000002_FFFFFFFF};
`else
        exp2 = {2'b01, 64'h00000002_00000010};
`endif
        checks++;
        if ({out_ovf_o, out_data_o} !== exp2) begin
            errors++;
            $display("FAIL ovf_sat: got %b_%h exp %b_%h", out_ovf_o, out_data_o,
                     exp2[65:64], exp2[63:0]);
        end
        checks++;
        if (err_order_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_err: got %b exp 0", err_order_o);
        end
    endtask

    task automatic test_order();
        logic acc;
        do_reset(1'b0);
        drive(1, 32'h7, 0, 1, 0, 0, acc);
        checks++;
        if ({err_order_o, out_ovf_o, out_data_o} !== {1'b1, 2'b00, 64'h00000007_00000000}) begin
            errors++;
            $display("FAIL order_word: got err=%b %b_%h exp 1 00_0000000700000000",
                     err_order_o, out_ovf_o, out_data_o);
        end
        for (int k = 0; k < 5; k++) drive(0, 32'h0, 0, 0, 0, 1, acc);
        checks++;
        if ({err_order_o, count_o} !== {1'b1, CW'(0)}) begin
            errors++;
            $display("FAIL order_sticky: got err=%b count=%0d exp 1/0", err_order_o, count_o);
        end
    endtask

    task automatic test_flush();
        logic acc;
        do_reset(1'b0);
        drive(1, 32'h33, 0, 0, 0, 0, acc);
        drive(1, 32'hDEAD, 0, 1, 1, 0, acc);
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b exp 0", in_ready_o);
        end
        checks++;
        if ({count_o, out_ovf_o, out_data_o} !== {CW'(1), 2'b00, 64'h00000000_00000033}) begin
            errors++;
            $display("FAIL flush_word: got count=%0d %b_%h exp 1 00_0000000000000033",
                     count_o, out_ovf_o, out_data_o);
        end
        // A clean pair afterwards proves the pending lower was retired.
        drive(1, 32'h1, 0, 0, 0, 1, acc);
        drive(1, 32'h2, 0, 1, 0, 1, acc);
        checks++;
        if ({err_order_o, count_o, out_data_o} !== {1'b0, CW'(1), 64'h00000002_00000001}) begin
            errors++;
            $display("FAIL flush_after: got err=%b count=%0d %h exp 0/1/0000000200000001",
                     err_order_o, count_o, out_data_o);
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        do_reset(1'b0);
        drive(1, 32'h5, 0, 0, 0, 0, acc);
        drive(1, 32'hA, 0, 1, 0, 0, acc);
        drive(1, 32'h77, 0, 0, 0, 0, acc);
        do_reset(1'b1);
        checks++;
        if ({count_o, out_valid_o, err_order_o} !== {CW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_clear: got count=%0d v=%b err=%b exp 0/0/0",
                     count_o, out_valid_o, err_order_o);
        end
        drive(1, 32'h9, 0, 1, 0, 0, acc);
        checks++;
        if ({err_order_o, out_data_o} !== {1'b1, 64'h00000009_00000000}) begin
            errors++;
            $display("FAIL rstmid_order: got err=%b %h exp 1/0000000900000000",
                     err_order_o, out_data_o);
        end
    endtask

    task automatic test_random();
        logic acc;
        do_reset(1'b0);
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0, acc);
            checks++;
            if ({count_o, out_valid_o, err_order_o, in_ready_o} !==
                {CW'(m_q.size()), m_q.size() != 0, m_err, (m_q.size() < DEPTH) && !flush_i}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got count=%0d v=%b err=%b rdy=%b exp count=%0d err=%b",
                         n, count_o, out_valid_o, err_order_o, in_ready_o, m_q.size(), m_err);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({out_ovf_o, out_data_o} !== m_q[0]) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got %b_%h exp %b_%h", n,
                             out_ovf_o, out_data_o, m_q[0][65:64], m_q[0][63:0]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pair();
        test_backpressure();
        test_overflow();
        test_order();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
